// File: rtl/k12a_mem_arbiter.sv
// SRAM port arbiter between the K12A CPU control FSM and an external DMA/loader port.
// Define K12A_MEM_ARB_STARVE_GUARD_EN to enable the DMA starvation guard.
module k12a_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic {ArbIdle, ArbAck} arb_state_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

  arb_state_e state_q, state_d;
  owner_e     owner;
  logic [7:0] dma_rdata_q, dma_rdata_d;
  logic       dma_eligible;
  logic       force_dma;

  // The ack cycle blocks DMA so a still-held request is not transferred twice.
  assign dma_eligible = (state_q == ArbIdle) && dma_req;

`ifdef K12A_MEM_ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign force_dma = dma_eligible && ({28'd0, wait_cnt_q} >= STARVE_LIMIT);
  assign cpu_stall = cpu_mem_enable && (owner == OwnDma);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (owner == OwnDma) begin
      wait_cnt_d = 4'd0;
    end else if (dma_eligible && (owner == OwnCpu) && (wait_cnt_q != 4'hf)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_starve_limit;

  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_dma = 1'b0;
  assign cpu_stall = 1'b0;
`endif

  always_comb begin
    owner = OwnNone;
    if (!reset_n) begin
      owner = OwnNone;
    end else if (force_dma) begin
      owner = OwnDma;
    end else if (cpu_mem_enable) begin
      owner = OwnCpu;
    end else if (dma_eligible) begin
      owner = OwnDma;
    end
  end

  always_comb begin
    mem_ce_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (owner)
      OwnCpu: begin
        mem_ce_n  = 1'b0;
        mem_oe_n  = cpu_mem_mode;
        mem_we_n  = ~cpu_mem_mode;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OwnDma: begin
        mem_ce_n  = 1'b0;
        mem_oe_n  = dma_we;
        mem_we_n  = ~dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = (owner == OwnDma) ? ArbAck : ArbIdle;
    dma_rdata_d = dma_rdata_q;
    if ((owner == OwnDma) && !dma_we) begin
      dma_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ArbIdle;
      dma_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign dma_ack   = (state_q == ArbAck);
  assign dma_rdata = dma_rdata_q;
  assign cpu_rdata = mem_rdata;

endmodule

// File: doc/k12a_mem_arbiter.md
# k12a_mem_arbiter

Shares the K12A's single asynchronous SRAM port between the CPU control FSM and an external DMA/loader port. Each clock cycle the block picks one owner, drives the SRAM strobes, address and write data from that owner, and completes DMA transfers with a registered acknowledge. The CPU normally has priority. An optional starvation guard periodically stalls the CPU for one cycle so that a waiting DMA transfer can complete. The block sits between the CPU core (the FSM's `mem_enable`/`mem_mode` plus the address and data buses) and the SRAM pins.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: number of consecutive cycles a DMA request may lose to the CPU before it is forced; legal range 1..15.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `cpu_mem_enable`  in  1  CPU requests memory this cycle
- `cpu_mem_mode`  in  1  0 = read, 1 = write
- `cpu_addr`  in  16  CPU address bus
- `cpu_wdata`  in  8  CPU data bus (write data)
- `cpu_rdata`  out  8  read data to CPU; combinational pass-through of `mem_rdata`
- `cpu_stall`  out  1  CPU must hold its state register this cycle
- `dma_req`  in  1  DMA transfer pending; held with address/data until `dma_ack`
- `dma_we`  in  1  0 = read, 1 = write
- `dma_addr`  in  16  DMA address
- `dma_wdata`  in  8  DMA write data
- `dma_ack`  out  1  one-cycle pulse; the transfer completed in the previous cycle
- `dma_rdata`  out  8  registered read data, valid while `dma_ack` = 1
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1 each  SRAM strobes, active low
- `mem_addr`  out  16  SRAM address
- `mem_wdata`  out  8  SRAM write data
- `mem_rdata`  in  8  SRAM read data

## Operation
State machine, with a registered state plus `wait_cnt` (4 bits):
- `ARB_IDLE`: DMA is eligible this cycle.
- `ARB_ACK`: `dma_ack` = 1 this cycle; DMA is not eligible, which prevents a held request from being transferred twice. Always returns to `ARB_IDLE` on the next cycle.

Owner selection each cycle, evaluated in order:
1. If `reset_n` = 0: no owner.
2. If state = `ARB_IDLE`, `dma_req` = 1, and the force condition holds (`wait_cnt` ≥ `STARVE_LIMIT`): owner is DMA.
3. Else if `cpu_mem_enable` = 1: owner is CPU.
4. Else if state = `ARB_IDLE` and `dma_req` = 1: owner is DMA.
5. Otherwise: no owner.

Outputs by owner:
- No owner: `mem_ce_n` = `mem_oe_n` = `mem_we_n` = 1; `mem_addr` = 0; `mem_wdata` = 0.
- CPU owner: `mem_ce_n` = 0. A read drives `mem_oe_n` = 0; a write drives `mem_we_n` = 0. Address and data come from the CPU.
- DMA owner: same strobe rules using `dma_we`, with address and data from the DMA port.

DMA owner side effects:
- At the clock edge, the state moves to `ARB_ACK`.
- `dma_rdata` ← `mem_rdata` on a read; it holds its previous value on a write.
- `wait_cnt` ← 0.

`cpu_stall` = `cpu_mem_enable` AND (owner = DMA). It can be 1 only through a forced grant.

`wait_cnt` updates:
- Increments, saturating at 15, in any cycle where `dma_req` = 1, state = `ARB_IDLE`, and the CPU owns the bus.
- Otherwise it holds, except that it clears on a DMA grant.

Reset (`reset_n` = 0 sampled at an edge):
- State → `ARB_IDLE`, `wait_cnt` → 0, `dma_ack` → 0, `dma_rdata` → 0x00.
- A transfer caught mid-operation is abandoned and never acknowledged. The requester must re-present it.

## Timing
- CPU access: zero added latency; the SRAM is accessed in the same cycle as `cpu_mem_enable`.
- DMA access: the transfer happens in the grant cycle N. `dma_ack` and `dma_rdata` are valid in cycle N+1.
- The DMA requester may present its next request in cycle N+2 at the earliest. Maximum DMA throughput is one transfer per 2 cycles.
- Simultaneous CPU and DMA requests with no force condition: the CPU wins and `wait_cnt` increments.
- Worst-case DMA wait under continuous CPU traffic: `STARVE_LIMIT` + 1 cycles from the first eligible cycle to the grant.
- Reset values: all `mem_*` strobes = 1, `mem_addr` = 0, `mem_wdata` = 0, `cpu_stall` = 0, `dma_ack` = 0, `dma_rdata` = 0x00. `cpu_rdata` follows `mem_rdata`.

## Configuration
- `K12A_MEM_ARB_STARVE_GUARD_EN` defined: the force condition, `wait_cnt`, and the `cpu_stall` logic are present, as described above.
- Macro undefined: strict CPU priority. Rule 2 never applies, `wait_cnt` is removed, and `cpu_stall` is tied to 0. DMA is served only in cycles where the CPU is idle; starvation is possible and accepted. `STARVE_LIMIT` is ignored.

## Test plan
- **Reset:** hold `reset_n` = 0 with `cpu_mem_enable` = 1 and `dma_req` = 1 → all strobes = 1, `dma_ack` = 0, `cpu_stall` = 0.
- **DMA read with CPU idle:** `dma_req` = 1, `dma_we` = 0, `dma_addr` = 0x1234, `mem_rdata` = 0xA5 → `mem_addr` = 0x1234 and `mem_oe_n` = 0 in cycle N; `dma_ack` = 1 and `dma_rdata` = 0xA5 in N+1; `mem_ce_n` = 1 in N+1 although `dma_req` is still held.
- **CPU write:** `cpu_mem_enable` = 1, `cpu_mem_mode` = 1, `cpu_addr` = 0x8000, `cpu_wdata` = 0x3C → same-cycle `mem_we_n` = 0, `mem_addr` = 0x8000, `mem_wdata` = 0x3C, `cpu_stall` = 0.
- **Starvation guard on (`STARVE_LIMIT` = 8):** CPU requests every cycle while `dma_req` = 1 → the CPU owns cycles 0–7; in cycle 8 DMA owns the bus and `cpu_stall` = 1; `dma_ack` in cycle 9; `wait_cnt` returns to 0.
- **Same stimulus with the macro undefined:** DMA is never granted over 100 cycles, `cpu_stall` stays 0; dropping `cpu_mem_enable` for one cycle grants DMA in that cycle.
- **Reset mid-transfer:** assert `reset_n` = 0 in a DMA grant cycle → no `dma_ack` in the following cycle; `dma_rdata` = 0x00.
